// File: rtl/show_sw_scan.sv
// DIP-switch change history on a multiplexed 7-segment display.
// Debounced switch values are pushed into a history, and the scan shows the newest value on digit 0.
module show_sw_scan #(
    parameter int NUM_DIG  = 8,
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CYC  = 100000,
    parameter int HEX_MODE = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] switch,
    output logic [7:0] num_csn,
    output logic [6:0] num_a_g,
    output logic [3:0] led,
    output logic [7:0] chg_cnt
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEB_CYC);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [2:0]        DIG_LAST  = 3'(NUM_DIG - 1);

    logic [3:0]        sync1;
    logic [3:0]        raw;
    logic [3:0]        cand;
    logic [DEB_W-1:0]  deb_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        dig_idx;
    logic [3:0]        hist [NUM_DIG];
    logic [NUM_DIG-1:0] vld;
    logic              commit;
    logic [3:0]        cur_val;
    logic              cur_vld;
    logic [7:0]        csn_next;
    logic [6:0]        seg_next;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'b1111110;
            4'h1: seg_of = 7'b0110000;
            4'h2: seg_of = 7'b1101101;
            4'h3: seg_of = 7'b1111001;
            4'h4: seg_of = 7'b0110011;
            4'h5: seg_of = 7'b1011011;
            4'h6: seg_of = 7'b1011111;
            4'h7: seg_of = 7'b1110000;
            4'h8: seg_of = 7'b1111111;
            4'h9: seg_of = 7'b1111011;
            4'hA: seg_of = 7'b1110111;
            4'hB: seg_of = 7'b0011111;
            4'hC: seg_of = 7'b1001110;
            4'hD: seg_of = 7'b0111101;
            4'hE: seg_of = 7'b1001111;
            default: seg_of = 7'b1000111;
        endcase
    endfunction

    // A candidate that has been stable for DEB_CYC cycles and differs from the newest entry is committed once.
    assign commit = (deb_cnt == DEB_LAST) && (cand != hist[0]);

    assign led = vld[1] ? ~hist[1] : 4'hF;

    always_comb begin
        cur_val  = 4'h0;
        cur_vld  = 1'b0;
        csn_next = 8'hFF;
        seg_next = 7'b0000000;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (dig_idx == 3'(i)) begin
                cur_val = hist[i];
                cur_vld = vld[i];
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (dig_idx == 3'(i)) csn_next[7-i] = 1'b0;
        end
        if (cur_vld && (HEX_MODE != 0 || cur_val < 4'd10)) seg_next = seg_of(cur_val);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1    <= 4'h0;
            raw      <= 4'h0;
            cand     <= 4'h0;
            deb_cnt  <= '0;
            scan_cnt <= '0;
            dig_idx  <= 3'd0;
            for (int i = 0; i < NUM_DIG; i++) hist[i] <= 4'h0;
            vld      <= NUM_DIG'(1);
            chg_cnt  <= 8'd0;
            num_csn  <= 8'hFF;
            num_a_g  <= 7'b0000000;
        end else begin
            sync1 <= ~switch;
            raw   <= sync1;

            if (raw != cand) begin
                cand    <= raw;
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            if (commit) begin
                for (int i = 1; i < NUM_DIG; i++) hist[i] <= hist[i-1];
                hist[0] <= cand;
                vld     <= {vld[NUM_DIG-2:0], 1'b1};
                chg_cnt <= chg_cnt + 8'd1;
            end

            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == DIG_LAST) ? 3'd0 : dig_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            // Select and segments come from the same registered state, so they always switch together.
            num_csn <= csn_next;
            num_a_g <= seg_next;
        end
    end

endmodule
